porta_automatica: RTL and testbench
===================================

PORTA_AUTOMATICA -- requirements
Module: porta_automatica

Interface
REQ-001 Parameter HOLD_CYCLES, default 50, clock cycles the door stays in ABERTO after the last open request.
REQ-002 Parameter TRAVEL_CYCLES, default 200, maximum clock cycles allowed in ABRINDO or FECHANDO before a fault.
REQ-003 Parameter CNT_W, default 16, counter width; the block SHALL require HOLD_CYCLES and TRAVEL_CYCLES to be at most 2^CNT_W-1.
REQ-004 clock  input  1  single system clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 pedido  input  1  open request, level.
REQ-007 trava  input  1  lock; blocks opening from FECHADO.
REQ-008 sensor_aberto  input  1  fully-open limit switch.
REQ-009 sensor_fechado  input  1  fully-closed limit switch.
REQ-010 obstaculo  input  1  obstruction detected in doorway.
REQ-011 motor_abrir, motor_fechar  output  1 each  motor drive; never both high.
REQ-012 ledVerde, ledVermelho  output  1 each  status LEDs.
REQ-013 HEX  output  7  7-segment code, active-low, bit order gfedcba.
REQ-014 estado  output  3  current state code.

Function
REQ-015 Moore FSM with states FECHADO=0, ABRINDO=1, ABERTO=2, FECHANDO=3, ERRO=4; all outputs decode from the registered state and counters only.
REQ-016 Inputs are sampled on the rising edge; a transition is visible on outputs in the same cycle it is registered (one edge after the enabling input).
REQ-017 FECHADO: pedido=1 and trava=0 -> ABRINDO; otherwise stay.
REQ-018 ABRINDO: sensor_aberto=1 -> ABERTO, hold counter loaded with HOLD_CYCLES; otherwise the travel counter increments, and on reaching TRAVEL_CYCLES-1 the next edge -> ERRO.
REQ-019 ABERTO: pedido=1 reloads the hold counter; otherwise it decrements; at zero -> FECHANDO.
REQ-020 FECHANDO: sensor_fechado=1 -> FECHADO; else pedido=1 -> ABRINDO; else the travel-timeout rule of REQ-018 applies.
REQ-021 The travel counter clears on every entry into ABRINDO or FECHANDO, including a reversal.
REQ-022 In ABRINDO or FECHANDO, sensor_aberto=1 together with sensor_fechado=1 -> ERRO, with priority over all other conditions.
REQ-023 ERRO is absorbing and is left only through reset.
REQ-024 motor_abrir=1 only in ABRINDO; motor_fechar=1 only in FECHANDO.
REQ-025 ledVerde=1 only in ABERTO; ledVermelho=1 in FECHADO and ERRO; both LEDs are 0 while moving.
REQ-026 HEX codes: FECHADO 0001110 (F), ABRINDO and FECHANDO 1000000 (O), ABERTO 0001000 (A), ERRO 0000110 (E).
REQ-027 In FECHADO, trava=1 overrides pedido.

Reset
REQ-028 reset=1 immediately forces FECHADO and clears both counters, from any state including mid-motion and ERRO.
REQ-029 Output values during and after reset: motor_abrir=0, motor_fechar=0, ledVerde=0, ledVermelho=1, HEX=0001110, estado=0.

Configuration
REQ-030 Macro PORTA_OBSTACULO_EN, when defined:
- obstaculo=1 in FECHANDO -> ABRINDO, with priority below REQ-022 and above sensor_fechado.
- obstaculo=1 in ABERTO holds the hold counter at its current value and blocks the exit to FECHANDO.
REQ-031 When PORTA_OBSTACULO_EN is undefined, obstaculo is ignored; the port remains present and unused.

Structure
REQ-032 Package porta_pkg SHALL hold the state encodings and the four HEX segment constants.
REQ-033 Sub-module porta_contador: a loadable up/down counter of width CNT_W with load, enable and zero flag, instantiated once for the hold counter and once for the travel counter.

Verification
All scenarios use HOLD_CYCLES=4 and TRAVEL_CYCLES=8.
REQ-034 Open/close cycle:
- Stimulus: reset, then pedido=1 for 1 cycle; sensor_aberto=1 after 3 cycles; later sensor_fechado=1.
- Response: F -> O (motor_abrir=1) -> A with ledVerde=1; FECHANDO exactly 4 cycles after entering ABERTO; FECHADO with HEX=0001110 after sensor_fechado.
REQ-035 Lock:
- Stimulus: trava=1 with pedido=1 for 10 cycles.
- Response: estado remains 0 and both motor outputs stay 0.
REQ-036 Travel timeout:
- Stimulus: ABRINDO entered with no sensor input.
- Response: ERRO on the 8th edge; HEX=0000110, ledVermelho=1; pedido then has no effect.
REQ-037 Reversal:
- Stimulus: in FECHANDO, pedido=1 (and, with PORTA_OBSTACULO_EN defined, separately obstaculo=1).
- Response: ABRINDO on the next edge with the travel counter cleared; obstaculo=1 without the macro causes no change.
REQ-038 Invalid sensors and reset:
- Stimulus: sensor_aberto=sensor_fechado=1 in FECHANDO.
- Response: ERRO; asserting reset between clock edges forces estado=0 and HEX=0001110 before the next edge.

Source files
------------

// File: rtl/porta_pkg.sv
// Shared encodings for the automatic door controller: state codes and
// active-low 7-segment patterns (bit order gfedcba).
package porta_pkg;

  localparam logic [2:0] ST_FECHADO  = 3'd0;
  localparam logic [2:0] ST_ABRINDO  = 3'd1;
  localparam logic [2:0] ST_ABERTO   = 3'd2;
  localparam logic [2:0] ST_FECHANDO = 3'd3;
  localparam logic [2:0] ST_ERRO     = 3'd4;

  localparam logic [6:0] HEX_F = 7'b0001110;
  localparam logic [6:0] HEX_O = 7'b1000000;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_E = 7'b0000110;

endpackage

// File: rtl/porta_contador.sv
// Loadable up/down counter with enable and zero flag, used for both the
// hold and the travel timers of the door controller.
module porta_contador #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= up ? count + CNT_W'(1) : count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/porta_automatica.sv
// Automatic door controller: Moore FSM with hold and travel timers.
// Optional obstruction handling is enabled by defining PORTA_OBSTACULO_EN.
//
// state    | meaning
// FECHADO  | door closed, waiting for an unlocked open request
// ABRINDO  | motor opening, travel timer running
// ABERTO   | door open, hold timer counting down
// FECHANDO | motor closing, travel timer running
// ERRO     | fault, left only through reset
module porta_automatica
  import porta_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50,
  parameter int TRAVEL_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedido,
  input  logic       trava,
  input  logic       sensor_aberto,
  input  logic       sensor_fechado,
  input  logic       obstaculo,
  output logic       motor_abrir,
  output logic       motor_fechar,
  output logic       ledVerde,
  output logic       ledVermelho,
  output logic [6:0] HEX,
  output logic [2:0] estado
);

  if (HOLD_CYCLES < 0 || TRAVEL_CYCLES < 0 ||
      longint'(HOLD_CYCLES) > (longint'(1) << CNT_W) - 1 ||
      longint'(TRAVEL_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_params
    $error("porta_automatica: HOLD_CYCLES/TRAVEL_CYCLES do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TRAVEL_LAST =
    (TRAVEL_CYCLES > 0) ? CNT_W'(TRAVEL_CYCLES - 1) : '0;

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] hold_cnt, travel_cnt;
  logic             hold_zero, travel_zero_unused;
  logic             hold_load, hold_dec, travel_clear, travel_inc;
  logic             sensors_bad, timeout, hold_done, obst;

`ifdef PORTA_OBSTACULO_EN
  assign obst = obstaculo;
`else
  logic obstaculo_unused;
  assign obstaculo_unused = obstaculo;
  assign obst = 1'b0;
`endif

  assign sensors_bad = sensor_aberto && sensor_fechado;
  assign timeout     = (travel_cnt == TRAVEL_LAST);
  // Exit on the edge that would bring the hold count to zero, so the door
  // leaves ABERTO exactly HOLD_CYCLES edges after the last load.
  assign hold_done   = hold_zero || (hold_cnt == CNT_W'(1));

  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    case (state)
      ST_FECHADO: begin
        if (pedido && !trava) state_next = ST_ABRINDO;
      end
      ST_ABRINDO: begin
        if (sensors_bad) begin
          state_next = ST_ERRO;
        end else if (sensor_aberto) begin
          state_next = ST_ABERTO;
          hold_load  = 1'b1;
        end else if (timeout) begin
          state_next = ST_ERRO;
        end
      end
      ST_ABERTO: begin
        if (pedido)          hold_load  = 1'b1;
        else if (obst)       hold_load  = 1'b0;
        else if (hold_done)  state_next = ST_FECHANDO;
        else                 hold_dec   = 1'b1;
      end
      ST_FECHANDO: begin
        if (sensors_bad)         state_next = ST_ERRO;
        else if (obst)           state_next = ST_ABRINDO;
        else if (sensor_fechado) state_next = ST_FECHADO;
        else if (pedido)         state_next = ST_ABRINDO;
        else if (timeout)        state_next = ST_ERRO;
      end
      ST_ERRO: state_next = ST_ERRO;
      default: state_next = ST_ERRO;
    endcase
  end

  // Any entry into a moving state, including a reversal, restarts travel.
  assign travel_clear = (state_next == ST_ABRINDO || state_next == ST_FECHANDO) &&
                        (state_next != state);
  assign travel_inc   = (state == ST_ABRINDO || state == ST_FECHANDO) &&
                        (state_next == state);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FECHADO;
    else       state <= state_next;
  end

  porta_contador #(.CNT_W(CNT_W)) u_hold (
    .clock      (clock),
    .reset      (reset),
    .load       (hold_load),
    .enable     (hold_dec),
    .up         (1'b0),
    .load_value (HOLD_LOAD),
    .count      (hold_cnt),
    .zero       (hold_zero)
  );

  porta_contador #(.CNT_W(CNT_W)) u_travel (
    .clock      (clock),
    .reset      (reset),
    .load       (travel_clear),
    .enable     (travel_inc),
    .up         (1'b1),
    .load_value ('0),
    .count      (travel_cnt),
    .zero       (travel_zero_unused)
  );

  always_comb begin
    motor_abrir  = 1'b0;
    motor_fechar = 1'b0;
    ledVerde     = 1'b0;
    ledVermelho  = 1'b0;
    HEX          = HEX_E;
    case (state)
      ST_FECHADO: begin
        ledVermelho = 1'b1;
        HEX         = HEX_F;
      end
      ST_ABRINDO: begin
        motor_abrir = 1'b1;
        HEX         = HEX_O;
      end
      ST_ABERTO: begin
        ledVerde = 1'b1;
        HEX      = HEX_A;
      end
      ST_FECHANDO: begin
        motor_fechar = 1'b1;
        HEX          = HEX_O;
      end
      default: begin
        ledVermelho = 1'b1;
        HEX         = HEX_E;
      end
    endcase
  end

  assign estado = state;

endmodule

// File: tb/tb_porta_automatica.sv
// Self-checking bench for porta_automatica with HOLD_CYCLES=4, TRAVEL_CYCLES=8:
// a vector table for the main sequences plus hand-written obstruction/reset cases.
module tb_porta_automatica;

  localparam int HOLD   = 4;
  localparam int TRAVEL = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pedido = 1'b0, trava = 1'b0, sensor_aberto = 1'b0;
  logic       sensor_fechado = 1'b0, obstaculo = 1'b0;
  logic       motor_abrir, motor_fechar, ledVerde, ledVermelho;
  logic [6:0] HEX;
  logic [2:0] estado;

  always #5 clock = ~clock;

  porta_automatica #(
    .HOLD_CYCLES   (HOLD),
    .TRAVEL_CYCLES (TRAVEL),
    .CNT_W         (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pedido         (pedido),
    .trava          (trava),
    .sensor_aberto  (sensor_aberto),
    .sensor_fechado (sensor_fechado),
    .obstaculo      (obstaculo),
    .motor_abrir    (motor_abrir),
    .motor_fechar   (motor_fechar),
    .ledVerde       (ledVerde),
    .ledVermelho    (ledVermelho),
    .HEX            (HEX),
    .estado         (estado)
  );

  typedef struct {
    logic       rst;
    logic       ped;
    logic       trv;
    logic       sa;
    logic       sf;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Expected {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX} per state.
  function automatic logic [10:0] exp_out(logic [2:0] st);
    case (st)
      3'd0:    return {4'b0001, 7'b0001110};
      3'd1:    return {4'b1000, 7'b1000000};
      3'd2:    return {4'b0010, 7'b0001000};
      3'd3:    return {4'b0100, 7'b1000000};
      default: return {4'b0001, 7'b0000110};
    endcase
  endfunction

  task automatic check(string name, logic [2:0] st);
    logic [10:0] got;
    got = {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX};
    checks++;
    if (estado !== st) begin
      errors++;
      $display("FAIL %s: estado=%0d expected %0d", name, estado, st);
    end
    checks++;
    if (got !== exp_out(st)) begin
      errors++;
      $display("FAIL %s: outputs=%b expected %b", name, got, exp_out(st));
    end
  endtask

  task automatic set_in(logic p, logic t, logic a, logic f, logic o);
    pedido = p; trava = t; sensor_aberto = a; sensor_fechado = f; obstaculo = o;
  endtask

  // Reset asserted mid-cycle; outputs must change before the next edge.
  task automatic do_reset(string name);
    @(negedge clock);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    #2;
    check(name, 3'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(logic p, logic t, logic a, logic f, logic o);
    @(negedge clock);
    set_in(p, t, a, f, o);
    @(posedge clock);
    #1;
  endtask

  function automatic void add(logic rst, logic ped, logic trv, logic sa, logic sf,
                              logic [2:0] st);
    vec_t v;
    v.rst = rst; v.ped = ped; v.trv = trv; v.sa = sa; v.sf = sf; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic void idle(int n, logic [2:0] st);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, st);
  endfunction

  initial begin
    // A: open/close cycle, lock, then travel timeout from ABRINDO
    add(1, 0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    idle(2, 3'd1);
    add(0, 0, 0, 1, 0, 3'd2);
    idle(3, 3'd2);
    add(0, 0, 0, 0, 0, 3'd3);
    add(0, 0, 0, 0, 0, 3'd3);
    add(0, 0, 0, 0, 1, 3'd0);
    for (int k = 0; k < 10; k++) add(0, 1, 1, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    idle(TRAVEL - 1, 3'd1);
    add(0, 0, 0, 0, 0, 3'd4);
    for (int k = 0; k < 3; k++) add(0, 1, 0, k[0], 0, 3'd4);
    // B: hold reload in ABERTO, then reversal clears the travel timer
    add(1, 0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    add(0, 0, 0, 1, 0, 3'd2);
    idle(2, 3'd2);
    add(0, 1, 0, 0, 0, 3'd2);
    idle(3, 3'd2);
    add(0, 0, 0, 0, 0, 3'd3);
    idle(3, 3'd3);
    add(0, 1, 0, 0, 0, 3'd1);
    idle(TRAVEL - 1, 3'd1);
    add(0, 0, 0, 0, 0, 3'd4);
    // C: both sensors in FECHANDO beat pedido
    add(1, 0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    add(0, 0, 0, 1, 0, 3'd2);
    idle(3, 3'd2);
    add(0, 0, 0, 0, 0, 3'd3);
    add(0, 1, 0, 1, 1, 3'd4);
    // D: both sensors in ABRINDO
    add(1, 0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    add(0, 0, 0, 1, 1, 3'd4);
    // E: sensor_fechado has priority over pedido in FECHANDO
    add(1, 0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1);
    add(0, 0, 0, 1, 0, 3'd2);
    idle(3, 3'd2);
    add(0, 0, 0, 0, 0, 3'd3);
    add(0, 1, 0, 0, 1, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset($sformatf("row%0d_reset", i));
      end else begin
        step(vecs[i].ped, vecs[i].trv, vecs[i].sa, vecs[i].sf, 1'b0);
        check($sformatf("row%0d", i), vecs[i].st);
      end
    end

    // Obstruction in FECHANDO
    do_reset("obst_fechando_reset");
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("obst_reach_fechando", 3'd3);
    step(0, 0, 0, 0, 1);
`ifdef PORTA_OBSTACULO_EN
    check("obst_fechando", 3'd1);
`else
    check("obst_fechando", 3'd3);
`endif

    // Obstruction in ABERTO
    do_reset("obst_aberto_reset");
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("obst_reach_aberto", 3'd2);
    for (int k = 0; k < HOLD; k++) step(0, 0, 0, 0, 1);
`ifdef PORTA_OBSTACULO_EN
    check("obst_aberto_hold", 3'd2);
    for (int k = 0; k < HOLD - 1; k++) step(0, 0, 0, 0, 0);
    check("obst_aberto_resume", 3'd2);
    step(0, 0, 0, 0, 0);
    check("obst_aberto_exit", 3'd3);
`else
    check("obst_aberto_ignored", 3'd3);
`endif

    // Reset from mid-motion and from ERRO
    do_reset("pre_motion_reset");
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("mid_motion", 3'd1);
    do_reset("reset_mid_motion");
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("reach_erro", 3'd4);
    do_reset("reset_from_erro");
    step(0, 0, 0, 0, 0);
    check("after_reset_idle", 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
